store_drain_buffer: RTL and testbench

// Committed-store FIFO between the ROB commit stage and datamem. Commit pushes each retiring store
// (address, data); the buffer drains one entry per accepted memory handshake, in program order.

---
 rtl/store_drain_buffer.sv | 101 ++++++++++
 tb/tb_store_drain_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_drain_buffer.sv
// Committed-store FIFO between ROB commit and datamem: in-order drain via a
// valid/ready write port, plus combinational youngest-match store-to-load forwarding.
module store_drain_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       push_valid_i,
  input  logic [AW-1:0]              push_addr_i,
  input  logic [DW-1:0]              push_data_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       mem_wr_en_o,
  output logic [AW-1:0]              mem_addr_o,
  output logic [DW-1:0]              mem_wdata_o,
  input  logic                       mem_ready_i,
  input  logic                       ld_valid_i,
  input  logic [AW-1:0]              ld_addr_i,
  output logic                       ld_hit_o,
  output logic [DW-1:0]              ld_data_o,
  output logic                       overflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [AW-1:0] WORD_MASK = {{(AW-2){1'b1}}, 2'b00};

  typedef enum logic {IDLE, REQ} state_t;

  state_t           state;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             push_ok;
  logic             pop;

  assign full_o      = (count == CW'(DEPTH));
  assign empty_o     = (count == '0);
  assign count_o     = count;
  assign push_ok     = push_valid_i && !full_o;
  assign pop         = (state == REQ) && mem_ready_i;
  assign count_next  = count + CW'(push_ok) - CW'(pop);
  assign mem_wr_en_o = (state == REQ);
  assign mem_addr_o  = mem_wr_en_o ? addr_q[head] : '0;
  assign mem_wdata_o = mem_wr_en_o ? data_q[head] : '0;

  // State follows the next count so a push is visible on the write port one cycle later.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state      <= IDLE;
      valid_q    <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push_ok) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + PW'(1);
      end
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      if (push_valid_i && full_o) overflow_o <= 1'b1;
      count <= count_next;
      state <= (count_next != '0) ? REQ : IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      addr_q[tail] <= push_addr_i;
      data_q[tail] <= push_data_i;
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    ld_hit_o  = 1'b0;
    ld_data_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (ld_valid_i && valid_q[idx] &&
          (((addr_q[idx] ^ ld_addr_i) & WORD_MASK) == '0)) begin
        ld_hit_o  = 1'b1;
        ld_data_o = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed self-checking bench for store_drain_buffer with hand-computed expectations.
module tb_store_drain_buffer;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        push_valid_i;
  logic [31:0] push_addr_i;
  logic [31:0] push_data_i;
  logic        full_o;
  logic        empty_o;
  logic [2:0]  count_o;
  logic        mem_wr_en_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic        ld_valid_i;
  logic [31:0] ld_addr_i;
  logic        ld_hit_o;
  logic [31:0] ld_data_o;
  logic        overflow_o;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  store_drain_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .push_valid_i (push_valid_i),
    .push_addr_i  (push_addr_i),
    .push_data_i  (push_data_i),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .count_o      (count_o),
    .mem_wr_en_o  (mem_wr_en_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ready_i  (mem_ready_i),
    .ld_valid_i   (ld_valid_i),
    .ld_addr_i    (ld_addr_i),
    .ld_hit_o     (ld_hit_o),
    .ld_data_o    (ld_data_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    push_valid_i = 1'b1;
    push_addr_i  = a;
    push_data_i  = d;
    tick();
    push_valid_i = 1'b0;
  endtask

  task automatic probe(input logic v, input logic [31:0] a);
    ld_valid_i = v;
    ld_addr_i  = a;
    #1;
  endtask

  initial begin
    reset_ni     = 1'b0;
    push_valid_i = 1'b0;
    push_addr_i  = '0;
    push_data_i  = '0;
    mem_ready_i  = 1'b0;
    ld_valid_i   = 1'b0;
    ld_addr_i    = '0;
    #3;
    check("rst_full",  full_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_count", count_o, 0);
    check("rst_wren",  mem_wr_en_o, 0);
    check("rst_addr",  mem_addr_o, 0);
    check("rst_wdata", mem_wdata_o, 0);
    check("rst_hit",   ld_hit_o, 0);
    check("rst_ldata", ld_data_o, 0);
    check("rst_ovf",   overflow_o, 0);
    #4 reset_ni = 1'b1;
    tick();

    // 1: single store, one-cycle push-to-write latency
    push(32'h100, 32'h11);
    check("t1_wren",  mem_wr_en_o, 1);
    check("t1_addr",  mem_addr_o, 32'h100);
    check("t1_wdata", mem_wdata_o, 32'h11);
    check("t1_count", count_o, 1);
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    check("t1_empty",  empty_o, 1);
    check("t1_wren0",  mem_wr_en_o, 0);
    check("t1_addr0",  mem_addr_o, 0);
    check("t1_wdata0", mem_wdata_o, 0);

    // 2: fill, then overflow
    for (int i = 0; i < 4; i++) push(32'h300 + 32'(4*i), 32'h30 + 32'(i));
    check("t2_full",  full_o, 1);
    check("t2_count", count_o, 4);
    check("t2_ovf0",  overflow_o, 0);
    push(32'h3F0, 32'hFF);
    check("t2_ovf",    overflow_o, 1);
    check("t2_count5", count_o, 4);
    check("t2_head",   mem_addr_o, 32'h300);
    mem_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t2_dr_addr", mem_addr_o, 32'h300 + 32'(4*k));
      check("t2_dr_data", mem_wdata_o, 32'h30 + 32'(k));
      tick();
    end
    mem_ready_i = 1'b0;
    check("t2_empty",  empty_o, 1);
    check("t2_wren0",  mem_wr_en_o, 0);
    check("t2_sticky", overflow_o, 1);

    // 3: forwarding
    push(32'h200, 32'hA);
    push(32'h204, 32'hB);
    push(32'h200, 32'hC);
    probe(1, 32'h202);
    check("t3_hit_202",  ld_hit_o, 1);
    check("t3_data_202", ld_data_o, 32'hC);
    probe(1, 32'h208);
    check("t3_hit_208",  ld_hit_o, 0);
    check("t3_data_208", ld_data_o, 0);
    probe(1, 32'h207);
    check("t3_hit_204",  ld_hit_o, 1);
    check("t3_data_204", ld_data_o, 32'hB);
    probe(0, 32'h200);
    check("t3_gate_hit",  ld_hit_o, 0);
    check("t3_gate_data", ld_data_o, 0);
    push_valid_i = 1'b1;
    push_addr_i  = 32'h208;
    push_data_i  = 32'hD;
    probe(1, 32'h208);
    check("t3_same_cyc_hit", ld_hit_o, 0);
    tick();
    push_valid_i = 1'b0;
    #1;
    check("t3_next_hit",  ld_hit_o, 1);
    check("t3_next_data", ld_data_o, 32'hD);
    mem_ready_i = 1'b1;
    tick(); tick(); tick();
    #1;
    check("t3_pop_hit",  ld_hit_o, 1);
    check("t3_pop_data", ld_data_o, 32'hD);
    tick();
    mem_ready_i = 1'b0;
    #1;
    check("t3_drained", empty_o, 1);
    check("t3_gone_hit", ld_hit_o, 0);
    probe(0, 32'h0);

    // 4: streaming one store per cycle across pointer wrap
    mem_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(32'h400 + 32'(4*i), 32'h40 + 32'(i));
      check("t4_wren",  mem_wr_en_o, 1);
      check("t4_addr",  mem_addr_o, 32'h400 + 32'(4*i));
      check("t4_data",  mem_wdata_o, 32'h40 + 32'(i));
      check("t4_count", count_o, 1);
    end
    tick();
    mem_ready_i = 1'b0;
    check("t4_empty", empty_o, 1);
    check("t4_wren0", mem_wr_en_o, 0);

    // 6: async reset while requesting
    push(32'h500, 32'h50);
    push(32'h504, 32'h54);
    check("t6_wren",  mem_wr_en_o, 1);
    check("t6_count", count_o, 2);
    #2 reset_ni = 1'b0;
    #1;
    check("t6_wren0",  mem_wr_en_o, 0);
    check("t6_count0", count_o, 0);
    check("t6_empty",  empty_o, 1);
    check("t6_ovf0",   overflow_o, 0);
    #2 reset_ni = 1'b1;
    mem_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_no_stale", mem_wr_en_o, 0);
    end
    mem_ready_i = 1'b0;

    // 5: push rejected while full even with a simultaneous pop
    for (int i = 0; i < 4; i++) push(32'h600 + 32'(4*i), 32'h60 + 32'(i));
    check("t5_full", full_o, 1);
    check("t5_ovf0", overflow_o, 0);
    mem_ready_i = 1'b1;
    push(32'h6F0, 32'hF0);
    check("t5_ovf",   overflow_o, 1);
    check("t5_count", count_o, 3);
    check("t5_nfull", full_o, 0);
    for (int k = 1; k < 4; k++) begin
      check("t5_dr_addr", mem_addr_o, 32'h600 + 32'(4*k));
      tick();
    end
    mem_ready_i = 1'b0;
    check("t5_empty", empty_o, 1);
    check("t5_wren0", mem_wr_en_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
